// File: rtl/freq_meas_sequencer.sv
// Measurement-cycle sequencer for the BCD event counter: clear, gate, settle,
// latch, evaluate, with manual or overflow/underfill driven auto-ranging.
module freq_meas_sequencer #(
  parameter int TICKS_1MS  = 50000,
  parameter int CLR_CYC    = 2,
  parameter int SETTLE_CYC = 4
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       run,
  input  logic       auto_range,
  input  logic [2:0] range_sel,
  input  logic       cnt_ovf,
  input  logic       cnt_msd_zero,
  output logic       gate,
  output logic       cnt_clr,
  output logic       latch,
  output logic       meas_valid,
  output logic       over_range,
  output logic [2:0] range_cur,
  output logic [2:0] dp_pos,
  output logic       busy
);

  localparam int              PW      = (TICKS_1MS > 1) ? $clog2(TICKS_1MS) : 1;
  localparam logic [PW-1:0]   PRE_MAX = PW'(TICKS_1MS - 1);
  localparam logic [3:0]      CLR_MAX = 4'(CLR_CYC - 1);
  localparam logic [3:0]      SET_MAX = 4'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_GATE, S_SETTLE, S_LATCH, S_EVAL
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pre_cnt, pre_nxt;
  logic [13:0]   ms_cnt, ms_nxt, ms_max;
  logic [3:0]    cyc_cnt, cyc_nxt;
  logic [2:0]    range_nxt, sel_clip;
  logic          ovf_q, msd_q, discard_q, discard_nxt;

  assign sel_clip = (range_sel > 3'd4) ? 3'd4 : range_sel;

  // Last millisecond index of the gate window: 10^range_cur - 1.
  always_comb begin
    ms_max = 14'd9999;
    case (range_cur)
      3'd0:    ms_max = 14'd0;
      3'd1:    ms_max = 14'd9;
      3'd2:    ms_max = 14'd99;
      3'd3:    ms_max = 14'd999;
      default: ms_max = 14'd9999;
    endcase
  end

  // An overflowed auto-range result above range 0 is thrown away and retried.
  assign discard_nxt = cnt_ovf && auto_range && (range_cur != 3'd0);

  always_comb begin
    state_nxt = state;
    pre_nxt   = pre_cnt;
    ms_nxt    = ms_cnt;
    cyc_nxt   = cyc_cnt;
    range_nxt = range_cur;
    case (state)
      S_IDLE:   if (run) state_nxt = S_CLEAR;
      S_CLEAR:  if (cyc_cnt == CLR_MAX) state_nxt = S_GATE;
                else cyc_nxt = cyc_cnt + 4'd1;
      S_GATE: begin
        if (pre_cnt == PRE_MAX) begin
          pre_nxt = '0;
          if (ms_cnt == ms_max) state_nxt = S_SETTLE;
          else ms_nxt = ms_cnt + 14'd1;
        end else begin
          pre_nxt = pre_cnt + 1'b1;
        end
      end
      S_SETTLE: if (cyc_cnt == SET_MAX) state_nxt = S_LATCH;
                else cyc_nxt = cyc_cnt + 4'd1;
      S_LATCH:  state_nxt = S_EVAL;
      S_EVAL: begin
        if (discard_q) begin
          range_nxt = range_cur - 3'd1;
          state_nxt = S_CLEAR;
        end else begin
          if (auto_range && !ovf_q && msd_q && (range_cur < 3'd4))
            range_nxt = range_cur + 3'd1;
          state_nxt = run ? S_CLEAR : S_IDLE;
        end
      end
      default:  state_nxt = S_IDLE;
    endcase
    // Every state starts with its timers at zero.
    if (state_nxt != state) begin
      pre_nxt = '0;
      ms_nxt  = '0;
      cyc_nxt = '0;
    end
    if (state_nxt == S_CLEAR && state != S_CLEAR && !auto_range)
      range_nxt = sel_clip;
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state      <= S_IDLE;
      pre_cnt    <= '0;
      ms_cnt     <= '0;
      cyc_cnt    <= '0;
      range_cur  <= 3'd4;
      ovf_q      <= 1'b0;
      msd_q      <= 1'b0;
      discard_q  <= 1'b0;
      gate       <= 1'b0;
      cnt_clr    <= 1'b0;
      latch      <= 1'b0;
      busy       <= 1'b0;
      meas_valid <= 1'b0;
      over_range <= 1'b0;
      dp_pos     <= 3'd0;
    end else begin
      state     <= state_nxt;
      pre_cnt   <= pre_nxt;
      ms_cnt    <= ms_nxt;
      cyc_cnt   <= cyc_nxt;
      range_cur <= range_nxt;
      gate      <= (state_nxt == S_GATE);
      cnt_clr   <= (state_nxt == S_CLEAR);
      latch     <= (state_nxt == S_LATCH);
      busy      <= (state_nxt != S_IDLE);
      if (state == S_LATCH) begin
        ovf_q     <= cnt_ovf;
        msd_q     <= cnt_msd_zero;
        discard_q <= discard_nxt;
      end
      // The result is published while the block sits in EVAL.
      meas_valid <= (state == S_LATCH) && !discard_nxt;
      if (state == S_LATCH && !discard_nxt) begin
        over_range <= cnt_ovf;
        dp_pos     <= range_cur;
      end
    end
  end

endmodule
